mult_issue_ctrl: RTL and testbench

- Hardware initiator for the generic_mult valid/ready operand interface.
- Buffers operand requests from an upstream producer and issues them one at a time to a multiplier.
- Captures each product on the multiplier's ready and presents it on a downstream result stream with an error flag.
- Sits between datapath sequencers and any generic_mult instance. Drives the multiplier's en for clock gating.

---
 rtl/mult_issue_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_mult_issue_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl
//
// Issues buffered multiply requests to a generic_mult instance one at a time.
// It also returns each product, or an error, on a downstream valid/ready
// result stream.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   s_valid/s_ready           upstream request handshake
//   s_precision               requested precision (4, 8, 16 or 32 are legal)
//   s_jia, s_yi               signed operands
//   m_en                      multiplier enable / clock gate (registered)
//   m_precision, m_jia, m_yi  conditioned operands presented to the multiplier
//   m_valid/m_ready           operand valid / product valid handshake
//   m_zi                      signed product from the multiplier
//   r_valid/r_ready           downstream result handshake
//   r_zi                      product (0 when r_err is set)
//   r_err                     timeout or illegal precision
module mult_issue_ctrl #(
  parameter int MAX_PRECISION = 32,
  parameter int DEPTH         = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [5:0]                   s_precision,
  input  logic [MAX_PRECISION-1:0]     s_jia,
  input  logic [MAX_PRECISION-1:0]     s_yi,
  output logic                         m_en,
  output logic [5:0]                   m_precision,
  output logic [MAX_PRECISION-1:0]     m_jia,
  output logic [MAX_PRECISION-1:0]     m_yi,
  output logic                         m_valid,
  input  logic                         m_ready,
  input  logic [2*MAX_PRECISION-1:0]   m_zi,
  output logic                         r_valid,
  input  logic                         r_ready,
  output logic [2*MAX_PRECISION-1:0]   r_zi,
  output logic                         r_err
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [AW:0]   FIFO_FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Keep the low p bits and sign-extend them to the full operand width.
  // A left shift followed by an arithmetic right shift does this for any
  // legal p without a per-precision case list.
  function automatic logic [MAX_PRECISION-1:0] signExt(
    input logic [MAX_PRECISION-1:0] v,
    input logic [5:0]               p
  );
    logic [7:0]               shAmt;
    logic [MAX_PRECISION-1:0] shifted;
    shAmt   = 8'(MAX_PRECISION) - {2'b00, p};
    shifted = v << shAmt;
    return $signed(shifted) >>> shAmt;
  endfunction

  function automatic logic isLegal(input logic [5:0] p);
    return (p == 6'd4) || (p == 6'd8) || (p == 6'd16) || (p == 6'd32);
  endfunction

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [5:0]               precMem [DEPTH];
  logic [MAX_PRECISION-1:0] jiaMem  [DEPTH];
  logic [MAX_PRECISION-1:0] yiMem   [DEPTH];

  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q;
  logic          fifoEmpty, fifoFull, push, pop;
  logic [5:0]    headPrec;
  logic          headLegal;

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == FIFO_FULL_COUNT);
  assign s_ready   = !fifoFull;
  assign push      = s_valid && s_ready;
  assign headPrec  = precMem[rdPtr_q];
  assign headLegal = isLegal(headPrec);

  // The storage array itself needs no reset; the occupancy count alone
  // decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      precMem[wrPtr_q] <= s_precision;
      jiaMem[wrPtr_q]  <= s_jia;
      yiMem[wrPtr_q]   <= s_yi;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and output registers
  // ---------------------------------------------------------------------------
  state_e                     state_q, state_d;
  logic [CW-1:0]              timeoutCnt_q, timeoutCnt_d;
  logic                       m_en_q, m_en_d;
  logic                       m_valid_q, m_valid_d;
  logic [5:0]                 m_precision_q, m_precision_d;
  logic [MAX_PRECISION-1:0]   m_jia_q, m_jia_d;
  logic [MAX_PRECISION-1:0]   m_yi_q, m_yi_d;
  logic                       r_valid_q, r_valid_d;
  logic [2*MAX_PRECISION-1:0] r_zi_q, r_zi_d;
  logic                       r_err_q, r_err_d;
  logic                       timeoutHit;
  logic                       resultTaken;

  assign timeoutHit  = (state_q == ISSUE) && !m_ready && (timeoutCnt_q == TIMEOUT_LAST);
  assign resultTaken = r_valid_q && r_ready;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      timeoutCnt_q  <= '0;
      m_en_q        <= 1'b0;
      m_valid_q     <= 1'b0;
      m_precision_q <= '0;
      m_jia_q       <= '0;
      m_yi_q        <= '0;
      r_valid_q     <= 1'b0;
      r_zi_q        <= '0;
      r_err_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timeoutCnt_q  <= timeoutCnt_d;
      m_en_q        <= m_en_d;
      m_valid_q     <= m_valid_d;
      m_precision_q <= m_precision_d;
      m_jia_q       <= m_jia_d;
      m_yi_q        <= m_yi_d;
      r_valid_q     <= r_valid_d;
      r_zi_q        <= r_zi_d;
      r_err_q       <= r_err_d;
    end
  end

  // Next-state logic. Leaving IDLE waits for the registered m_en, so the
  // multiplier clock gate is already open by the time operands are
  // presented. From HOLD, m_en is still high, so back-to-back issue loses
  // no cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifoEmpty && m_en_q) begin
          pop     = 1'b1;
          state_d = headLegal ? ISSUE : HOLD;
        end
      end
      ISSUE: begin
        if (m_ready || timeoutHit) state_d = HOLD;
      end
      HOLD: begin
        if (resultTaken) begin
          if (fifoEmpty) begin
            state_d = IDLE;
          end else begin
            pop     = 1'b1;
            state_d = headLegal ? ISSUE : HOLD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The transaction-end and handshake updates are evaluated
  // first. A pop in the same cycle then overrides them, so an illegal head
  // popped from HOLD shows up at once as the next (error) result.
  always_comb begin
    m_en_d        = !fifoEmpty || (state_q != IDLE);
    timeoutCnt_d  = '0;
    m_valid_d     = m_valid_q;
    m_precision_d = m_precision_q;
    m_jia_d       = m_jia_q;
    m_yi_d        = m_yi_q;
    r_valid_d     = r_valid_q;
    r_zi_d        = r_zi_q;
    r_err_d       = r_err_q;

    if (state_q == ISSUE) begin
      if (m_ready) begin
        r_zi_d    = m_zi;
        r_err_d   = 1'b0;
        r_valid_d = 1'b1;
        m_valid_d = 1'b0;
      end else if (timeoutHit) begin
        r_zi_d    = '0;
        r_err_d   = 1'b1;
        r_valid_d = 1'b1;
        m_valid_d = 1'b0;
      end else begin
        timeoutCnt_d = timeoutCnt_q + 1'b1;
      end
    end

    if ((state_q == HOLD) && resultTaken) begin
      r_valid_d = 1'b0;
    end

    if (pop) begin
      if (headLegal) begin
        m_precision_d = headPrec;
        m_jia_d       = signExt(jiaMem[rdPtr_q], headPrec);
        m_yi_d        = signExt(yiMem[rdPtr_q], headPrec);
        m_valid_d     = 1'b1;
      end else begin
        r_zi_d    = '0;
        r_err_d   = 1'b1;
        r_valid_d = 1'b1;
      end
    end
  end

  assign m_en        = m_en_q;
  assign m_valid     = m_valid_q;
  assign m_precision = m_precision_q;
  assign m_jia       = m_jia_q;
  assign m_yi        = m_yi_q;
  assign r_valid     = r_valid_q;
  assign r_zi        = r_zi_q;
  assign r_err       = r_err_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed testbench for mult_issue_ctrl. The bench plays the role of
// the multiplier by driving m_ready/m_zi with hand-computed products.
module tb_mult_issue_ctrl;

  localparam int MP      = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic            clk;
  logic            rst;
  logic            s_valid;
  logic            s_ready;
  logic [5:0]      s_precision;
  logic [MP-1:0]   s_jia;
  logic [MP-1:0]   s_yi;
  logic            m_en;
  logic [5:0]      m_precision;
  logic [MP-1:0]   m_jia;
  logic [MP-1:0]   m_yi;
  logic            m_valid;
  logic            m_ready;
  logic [2*MP-1:0] m_zi;
  logic            r_valid;
  logic            r_ready;
  logic [2*MP-1:0] r_zi;
  logic            r_err;

  int compareCount;
  int failCount;

  mult_issue_ctrl #(
    .MAX_PRECISION(MP),
    .DEPTH(DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_precision(s_precision),
    .s_jia(s_jia),
    .s_yi(s_yi),
    .m_en(m_en),
    .m_precision(m_precision),
    .m_jia(m_jia),
    .m_yi(m_yi),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_zi(m_zi),
    .r_valid(r_valid),
    .r_ready(r_ready),
    .r_zi(r_zi),
    .r_err(r_err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Push one request, waiting a bounded time for s_ready
  task automatic applyStimulus(input logic [5:0] p, input logic [MP-1:0] a, input logic [MP-1:0] b);
    int n;
    n = 0;
    s_valid     = 1'b1;
    s_precision = p;
    s_jia       = a;
    s_yi        = b;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    checkOutput("push_accept", 64'(s_ready), 64'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic waitMValid(input int budget);
    int n;
    n = 0;
    while (!m_valid && n < budget) begin
      tick();
      n++;
    end
    checkOutput("mvalid_wait", 64'(m_valid), 64'd1);
  endtask

  // Answer the current issue with a product and step into HOLD
  task automatic respond(input logic [63:0] product);
    m_ready = 1'b1;
    m_zi    = product;
    tick();
    m_ready = 1'b0;
    m_zi    = '0;
  endtask

  logic [MP-1:0] bpA    [5];
  logic [MP-1:0] bpB    [5];
  logic [63:0]   bpProd [5];

  initial begin
    int n;
    logic seenMValid;

    compareCount = 0;
    failCount    = 0;
    rst          = 1'b1;
    s_valid      = 1'b0;
    s_precision  = '0;
    s_jia        = '0;
    s_yi         = '0;
    m_ready      = 1'b0;
    m_zi         = '0;
    r_ready      = 1'b0;

    bpA    = '{32'd1, 32'd3, 32'd5, 32'd7, 32'hFFFFFFFF};
    bpB    = '{32'd2, 32'd4, 32'd6, 32'd8, 32'd9};
    bpProd = '{64'd2, 64'd12, 64'd30, 64'd56, -64'sd9};

    // Reset values
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("rst_s_ready", 64'(s_ready), 64'd1);
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_m_en", 64'(m_en), 64'd0);
    checkOutput("rst_r_valid", 64'(r_valid), 64'd0);
    checkOutput("rst_r_err", 64'(r_err), 64'd0);
    checkOutput("rst_r_zi", r_zi, 64'd0);
    checkOutput("rst_m_jia", 64'(m_jia), 64'd0);
    checkOutput("rst_m_prec", 64'(m_precision), 64'd0);

    // p=8, 8*31, multiplier answers 3 cycles after m_valid
    applyStimulus(6'd8, 32'd8, 32'd31);
    checkOutput("lat_mvalid_push", 64'(m_valid), 64'd0);
    tick();
    checkOutput("lat_men_early", 64'(m_en), 64'd1);
    checkOutput("lat_mvalid_1", 64'(m_valid), 64'd0);
    tick();
    checkOutput("lat_mvalid_2", 64'(m_valid), 64'd1);
    checkOutput("t1_m_prec", 64'(m_precision), 64'd8);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t1_hold_mvalid", 64'(m_valid), 64'd1);
      checkOutput("t1_hold_jia", 64'(m_jia), 64'd8);
      checkOutput("t1_hold_yi", 64'(m_yi), 64'd31);
      tick();
    end
    respond(64'd248);
    checkOutput("t1_mvalid_drop", 64'(m_valid), 64'd0);
    checkOutput("t1_r_valid", 64'(r_valid), 64'd1);
    checkOutput("t1_r_zi", r_zi, 64'd248);
    checkOutput("t1_r_err", 64'(r_err), 64'd0);
    tick();
    checkOutput("t1_r_held", r_zi, 64'd248);
    checkOutput("t1_r_valid_held", 64'(r_valid), 64'd1);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    checkOutput("t1_r_taken", 64'(r_valid), 64'd0);
    tick();
    checkOutput("t1_men_off", 64'(m_en), 64'd0);

    // Back-to-back at p=8 with r_ready held high
    r_ready = 1'b1;
    applyStimulus(6'd8, 32'hFFFFFFF8, 32'd2);
    applyStimulus(6'd8, 32'hFFFFFFF8, 32'd31);
    waitMValid(10);
    checkOutput("b2b_jia0", 64'(m_jia), 64'hFFFFFFF8);
    checkOutput("b2b_yi0", 64'(m_yi), 64'd2);
    respond(-64'sd16);
    checkOutput("b2b_r0_valid", 64'(r_valid), 64'd1);
    checkOutput("b2b_r0_zi", r_zi, -64'sd16);
    tick();
    checkOutput("b2b_reissue", 64'(m_valid), 64'd1);
    checkOutput("b2b_r_drop", 64'(r_valid), 64'd0);
    checkOutput("b2b_yi1", 64'(m_yi), 64'd31);
    respond(-64'sd248);
    checkOutput("b2b_r1_zi", r_zi, -64'sd248);
    checkOutput("b2b_r1_err", 64'(r_err), 64'd0);
    tick();
    checkOutput("b2b_idle_r", 64'(r_valid), 64'd0);
    checkOutput("b2b_idle_m", 64'(m_valid), 64'd0);
    r_ready = 1'b0;

    // p=4 truncation and sign extension: 8 -> 4'b1000 -> -8
    applyStimulus(6'd4, 32'd8, 32'd3);
    waitMValid(10);
    checkOutput("p4_jia", 64'(m_jia), 64'hFFFFFFF8);
    checkOutput("p4_yi", 64'(m_yi), 64'd3);
    checkOutput("p4_prec", 64'(m_precision), 64'd4);
    respond(-64'sd24);
    checkOutput("p4_r_zi", r_zi, -64'sd24);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;

    // Timeout, then the queued request issues normally
    applyStimulus(6'd16, 32'd100, 32'd200);
    applyStimulus(6'd16, 32'd3, 32'd5);
    waitMValid(10);
    n = 0;
    while (m_valid && n < 200) begin
      n++;
      tick();
    end
    checkOutput("to_cycles", 64'(n), 64'(TIMEOUT));
    checkOutput("to_r_valid", 64'(r_valid), 64'd1);
    checkOutput("to_r_err", 64'(r_err), 64'd1);
    checkOutput("to_r_zi", r_zi, 64'd0);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    checkOutput("to_next_issue", 64'(m_valid), 64'd1);
    checkOutput("to_next_jia", 64'(m_jia), 64'd3);
    respond(64'd15);
    checkOutput("to_next_zi", r_zi, 64'd15);
    checkOutput("to_next_err", 64'(r_err), 64'd0);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;

    // Backpressure: DEPTH+1 pushes with r_ready low
    for (int k = 0; k < DEPTH + 1; k++) begin
      applyStimulus(6'd8, bpA[k], bpB[k]);
    end
    checkOutput("bp_full", 64'(s_ready), 64'd0);
    checkOutput("bp_first_jia", 64'(m_jia), 64'd1);
    respond(bpProd[0]);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_hold_valid", 64'(r_valid), 64'd1);
      checkOutput("bp_hold_zi", r_zi, bpProd[0]);
      tick();
    end
    for (int k = 0; k < DEPTH + 1; k++) begin
      checkOutput("bp_drain_valid", 64'(r_valid), 64'd1);
      checkOutput("bp_drain_zi", r_zi, bpProd[k]);
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
      if (k < DEPTH) begin
        checkOutput("bp_next_issue", 64'(m_valid), 64'd1);
        checkOutput("bp_next_jia", 64'(m_jia), 64'(bpA[k+1]));
        checkOutput("bp_next_yi", 64'(m_yi), 64'(bpB[k+1]));
        respond(bpProd[k+1]);
      end
    end
    checkOutput("bp_done", 64'(r_valid), 64'd0);
    checkOutput("bp_s_ready", 64'(s_ready), 64'd1);

    // Illegal precision p=5: no issue, error result
    applyStimulus(6'd5, 32'd9, 32'd9);
    seenMValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid) seenMValid = 1'b1;
      tick();
    end
    checkOutput("p5_no_mvalid", 64'(seenMValid), 64'd0);
    checkOutput("p5_r_valid", 64'(r_valid), 64'd1);
    checkOutput("p5_r_err", 64'(r_err), 64'd1);
    checkOutput("p5_r_zi", r_zi, 64'd0);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    checkOutput("p5_taken", 64'(r_valid), 64'd0);

    // Reset while in ISSUE
    applyStimulus(6'd32, 32'd7, 32'hFFFFFFFD);
    waitMValid(10);
    checkOutput("rst_issue_jia", 64'(m_jia), 64'd7);
    rst = 1'b1;
    tick();
    checkOutput("rst_mid_mvalid", 64'(m_valid), 64'd0);
    checkOutput("rst_mid_rvalid", 64'(r_valid), 64'd0);
    checkOutput("rst_mid_sready", 64'(s_ready), 64'd1);
    rst = 1'b0;
    tick();
    checkOutput("rst_mid_idle", 64'(m_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
